// File: rtl/adder_tree_pipe_if.sv
// Operand-vector / result bundle for the pipelined adder tree.
// Latency: none (wires only); the tree's latency lives in the module itself.
// Backpressure: no ready path; en is a global stall driven by the master.
//
// Ports (master = producer/consumer side, slave = adder_tree_pipe):
//   en, flush, in_valid, din           master -> slave
//   out_valid, sum_full, dout, sat     slave  -> master
interface adder_tree_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ARR_L  = 9,
    parameter int OUT_W  = 8
);
    localparam int SUM_W = DATA_W + $clog2(ARR_L);

    logic                    en;
    logic                    flush;
    logic                    in_valid;
    logic [DATA_W*ARR_L-1:0] din;
    logic                    out_valid;
    logic [SUM_W-1:0]        sum_full;
    logic [OUT_W-1:0]        dout;
    logic                    sat;

    modport master (
        output en, flush, in_valid, din,
        input  out_valid, sum_full, dout, sat
    );

    modport slave (
        input  en, flush, in_valid, din,
        output out_valid, sum_full, dout, sat
    );
endinterface

// File: rtl/adder_tree_pipe.sv
// Pipelined N-input adder tree with rounding shift + saturation on the output.
// Latency: S + 1 enabled cycles, S = 1 (PIPE_INTERVAL=0) or ceil(L/PIPE_INTERVAL).
// Backpressure: en=0 freezes every register (valids too); flush clears all valids.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         adder_tree_pipe_if slave: en, flush, in_valid, din in;
//               out_valid, sum_full (exact), dout (normalised), sat out
module adder_tree_pipe #(
    parameter int DATA_W        = 8,
    parameter int ARR_L         = 9,
    parameter int PIPE_INTERVAL = 1,
    parameter int SIGNED        = 0,
    parameter int SHIFT         = 4,
    parameter int OUT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_tree_pipe_if.slave  bus
);
    localparam int L       = $clog2(ARR_L);
    localparam int SUM_W   = DATA_W + L;
    localparam int PI_SAFE = (PIPE_INTERVAL == 0) ? 1 : PIPE_INTERVAL;
    // Clip comparison width: wide enough to hold both the shifted sum and the
    // OUT_W limits as signed values without wrap.
    localparam int CW      = ((SUM_W + 1 > OUT_W + 1) ? SUM_W + 1 : OUT_W + 1) + 1;

    // Number of tree nodes present after level k.
    function automatic int level_cnt(input int k);
        int n;
        n = ARR_L;
        for (int i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic bit level_reg(input int k);
        return (k == L) || ((PIPE_INTERVAL != 0) && ((k % PI_SAFE) == 0));
    endfunction

    // ------------------------------------------------------------------
    // Tree. Every node is carried at SUM_W bits; the true sum never needs
    // more, so the extra headroom on early levels is arithmetically inert.
    // ------------------------------------------------------------------
    genvar k, j;
    generate
        for (k = 0; k <= L; k++) begin : g_lvl
            localparam int N = level_cnt(k);
            logic [SUM_W-1:0] q [N];
            logic             v;

            if (k == 0) begin : g_in
                for (j = 0; j < N; j++) begin : g_op
                    logic [DATA_W-1:0] op;
                    assign op = bus.din[j*DATA_W +: DATA_W];
                    if (SIGNED != 0) begin : g_sx
                        assign q[j] = {{L{op[DATA_W-1]}}, op};
                    end else begin : g_zx
                        assign q[j] = {{L{1'b0}}, op};
                    end
                end
                assign v = bus.in_valid;
            end else begin : g_add
                localparam int NP = level_cnt(k - 1);
                logic [SUM_W-1:0] c [N];

                // Pair from the low index; a trailing odd node passes through.
                for (j = 0; j < N; j++) begin : g_node
                    if (2*j + 1 < NP) begin : g_pair
                        assign c[j] = g_lvl[k-1].q[2*j] + g_lvl[k-1].q[2*j+1];
                    end else begin : g_pass
                        assign c[j] = g_lvl[k-1].q[2*j];
                    end
                end

                if (level_reg(k)) begin : g_reg
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            for (int i = 0; i < N; i++) q[i] <= '0;
                            v <= 1'b0;
                        end else begin
                            if (bus.en) begin
                                for (int i = 0; i < N; i++) q[i] <= c[i];
                            end
                            if (bus.flush)   v <= 1'b0;
                            else if (bus.en) v <= g_lvl[k-1].v;
                        end
                    end
                end else begin : g_comb
                    assign q = c;
                    assign v = g_lvl[k-1].v;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Normalisation: add half an LSB, shift, clip to OUT_W.
    // ------------------------------------------------------------------
    localparam int              SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [SUM_W:0]  RND_ONE  = 1;
    localparam logic [SUM_W:0]  RND      = (SHIFT > 0) ? (RND_ONE << SHIFT_M1) : '0;

    localparam logic signed [CW-1:0] ONE  = 1;
    localparam logic signed [CW-1:0] MAXV = (SIGNED != 0) ? (ONE <<< (OUT_W - 1)) - ONE
                                                          : (ONE <<< OUT_W) - ONE;
    localparam logic signed [CW-1:0] MINV = (SIGNED != 0) ? -(ONE <<< (OUT_W - 1)) : '0;

    logic [SUM_W-1:0]       sum;
    logic [SUM_W:0]         sum_x;
    logic [SUM_W:0]         rnd_sum;
    logic [SUM_W:0]         shf;
    logic signed [CW-1:0]   ext;
    logic                   sat_hi;
    logic                   sat_lo;
    logic [OUT_W-1:0]       dout_n;

    assign sum = g_lvl[L].q[0];

    generate
        if (SIGNED != 0) begin : g_norm_s
            logic signed [SUM_W:0] r_s;
            assign sum_x   = {sum[SUM_W-1], sum};
            assign rnd_sum = sum_x + RND;
            assign r_s     = rnd_sum;
            assign shf     = r_s >>> SHIFT;
            assign ext     = {{(CW-SUM_W-1){shf[SUM_W]}}, shf};
        end else begin : g_norm_u
            assign sum_x   = {1'b0, sum};
            assign rnd_sum = sum_x + RND;
            assign shf     = rnd_sum >> SHIFT;
            assign ext     = {{(CW-SUM_W-1){1'b0}}, shf};
        end
    endgenerate

    assign sat_hi = (ext > MAXV);
    assign sat_lo = (ext < MINV);
    assign dout_n = sat_hi ? MAXV[OUT_W-1:0] :
                    sat_lo ? MINV[OUT_W-1:0] : ext[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.sum_full  <= '0;
            bus.dout      <= '0;
            bus.sat       <= 1'b0;
        end else begin
            if (bus.en) begin
                bus.sum_full <= sum;
                bus.dout     <= dout_n;
                bus.sat      <= sat_hi | sat_lo;
            end
            if (bus.flush)   bus.out_valid <= 1'b0;
            else if (bus.en) bus.out_valid <= g_lvl[L].v;
        end
    end
endmodule

// File: doc/adder_tree_pipe.md
# adder_tree_pipe

Parametrised, fully pipelined N-input adder tree with valid tracking, global stall, synchronous flush, signed or unsigned operands, and an output normalisation stage: rounding right shift followed by saturation. It replaces the plain recursive adder tree in the SIFT filter datapaths (Gaussian or box kernels, DoG sums). It accepts one operand vector per enabled cycle and delivers both the full-precision sum and the normalised result at fixed latency.

## Interface
- DATA_W, 8: width of each operand.
- ARR_L, 9: number of operands; must be ≥ 2.
- PIPE_INTERVAL, 1: tree levels per register stage; 0 = a register only after the last level.
- SIGNED, 0: 1 = operands, sum and result are two's complement.
- SHIFT, 4: right shift applied in the normalisation stage (0..SUM_W-1).
- OUT_W, 8: width of the normalised output.
- Derived: L = ceil(log2(ARR_L)); SUM_W = DATA_W + L.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance; 0 freezes every register, valid bits included.
- flush  in  1  synchronous clear of all valid bits.
- in_valid  in  1  din qualifier.
- din  in  DATA_W*ARR_L  operand k at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  dout, sum_full and sat are valid.
- sum_full  out  SUM_W  exact sum; sign-extended when SIGNED=1.
- dout  out  OUT_W  rounded, shifted and saturated sum.
- sat  out  1  dout was clipped.

## Operation
- Tree: at each level, operands are paired from the low index up. An odd element passes through to the next level unchanged.
- Width grows 1 bit per level. Operands are sign-extended (SIGNED=1) or zero-extended (SIGNED=0). No overflow is possible.
- Register placement: a register follows tree level k (k = 1..L) when PIPE_INTERVAL ≠ 0 and k mod PIPE_INTERVAL = 0, or when k = L.
  - Pass-through elements are registered at the same stages, so all paths have equal depth.
- Normalisation stage, always registered:
  - r = sum + (SHIFT > 0 ? 2^(SHIFT-1) : 0), computed at SUM_W+1 bits.
  - Shift r right by SHIFT: arithmetic if SIGNED=1, logical otherwise. This gives round-half-up.
  - Clip the result to the OUT_W range: [0, 2^OUT_W−1] unsigned, or [−2^(OUT_W−1), 2^(OUT_W−1)−1] signed.
  - sat = 1 whenever clipping changed the value.
- sum_full is the exact tree sum, registered in the normalisation stage alongside dout.
- A valid bit travels with each stage. Data registers load whenever en = 1, regardless of valid.
- flush = 1: every valid bit is 0 after the edge, regardless of en. Data registers behave as normal.
- flush and in_valid in the same cycle: flush wins and the input is dropped.
- No state machine. The block is a pure pipeline with a valid shift chain.

## Timing
- Stage count: S = 1 (PIPE_INTERVAL = 0) or ceil(L / PIPE_INTERVAL). Latency LAT = S + 1 enabled cycles.
- Defaults: L = 4, SUM_W = 12, S = 4, LAT = 5.
- Throughput: one vector per enabled cycle. Back-to-back inputs produce back-to-back outputs.
- Stall: while en = 0, all outputs hold their values, including out_valid. The consumer samples on en & out_valid.
- Reset (rst_n = 0, asynchronous, any time, including mid-stream):
  - all valid bits, data registers, out_valid, sum_full, dout and sat go to 0 immediately;
  - in-flight data is lost;
  - the first valid input after rst_n deasserts appears LAT enabled cycles later.
- Once a valid vector has been accepted, no output appears before LAT enabled cycles have elapsed.

## Test plan
- Defaults, all din = 255, single in_valid pulse, en = 1 → exactly 5 cycles later: out_valid = 1 for one cycle, sum_full = 2295, dout = 143, sat = 0.
- Defaults with SHIFT = 0, OUT_W = 8, all din = 255 → sum_full = 2295, dout = 255, sat = 1.
- SIGNED = 1, SHIFT = 4, all din = 0x80 (−128) → sum_full = 0xB80 (−1152), dout = 0xB8 (−72), sat = 0. Same stimulus with SHIFT = 0 → dout = 0x80, sat = 1.
- Streaming with stall: 20 consecutive vectors with din[k] = i + k (i = vector number), en held low for 3 cycles in mid-stream → 20 outputs in order with sum_full = 9i + 36 and no gaps except the 3 held cycles. Output values are unchanged throughout the stall.
- Flush and reset: 3 vectors in flight, then flush asserted together with in_valid → no out_valid for those 4 vectors, and the next vector emerges at LAT. Repeat with rst_n pulsed low mid-stream → all outputs read 0 asynchronously and no stale output appears afterwards.
- Parameter sweep: ARR_L ∈ {2, 5, 9}, PIPE_INTERVAL ∈ {0, 1, 2}, SIGNED ∈ {0, 1}, random din → sum_full equals a reference model and latency equals LAT in every configuration (for example ARR_L = 5, PIPE_INTERVAL = 2: L = 3, LAT = 3).
